// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: upstream (in_*) and downstream (out_*)
// valid/ready channels sharing one payload width.
interface pipe_skid_stage_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   // environment side: produces upstream entries, consumes downstream entries
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // stage side
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_skid_stage.sv
// One-cycle pipeline stage with optional two-entry skid buffer.
// SKID=1: in_ready comes straight from a flop, so upstream timing is cut from
//         out_ready/stall/flush; a second (skid) entry absorbs the in-flight word.
// SKID=0: single register, in_ready is combinational from downstream.
// out_data always comes from the main register; the skid register only refills it.
module pipe_skid_stage #(
   parameter int              DATA_W       = 32,
   parameter int              SKID         = 1,
   parameter int              CLR_ON_FLUSH = 1,
   parameter logic [DATA_W-1:0] RST_VAL    = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               stall,
   pipe_skid_stage_if.slave   bus,
   output logic [1:0]         occ
);

   // state encoding doubles as the occupancy count
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   main_q, main_d;
   logic [DATA_W-1:0]   skid_q, skid_d;
   logic                in_ready_q, in_ready_d;
   logic                in_ready;
   logic                out_valid;
   logic                enq;
   logic                deq;

   assign out_valid = (state_q != EMPTY);
   // SKID=0 can hand its slot over in the same cycle it is drained
   assign in_ready  = (SKID != 0) ? in_ready_q
                                  : (!out_valid || (bus.out_ready && !stall));

   assign enq = bus.in_valid && in_ready && !flush;
   assign deq = out_valid && bus.out_ready && !stall && !flush;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = main_q;
   assign occ           = state_q;

   // state register; reset beats flush and everything else
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= RST_VAL;
         skid_q     <= RST_VAL;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   // next-state and datapath steering; flush discards both entries
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         if (CLR_ON_FLUSH != 0) begin
            main_d = RST_VAL;
            skid_d = RST_VAL;
         end
      end else begin
         case (state_q)
            EMPTY: begin
               if (enq) begin
                  state_d = ONE;
                  main_d  = bus.in_data;
               end
            end
            ONE: begin
               if (enq && deq) begin
                  main_d = bus.in_data;
               end else if (enq && (SKID != 0)) begin
                  // downstream did not take the head: park the newcomer
                  state_d = FULL;
                  skid_d  = bus.in_data;
               end else if (deq) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the skid->main move can happen
               if (deq) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      in_ready_d = (state_d != FULL);
   end

   // the single-register variant must never reach the second entry
   always_ff @(posedge clk) begin
      if (!rst) assert ((SKID != 0) || (state_q != FULL));
   end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: three instances cover the skid buffer,
// the single-register variant (hold-on-flush, non-zero reset value) and a
// 64-bit skid stage driven with a random stream against a queue model.
module tb_pipe_skid_stage;

   logic clk;
   logic rst_a, rst_b, rst_c;
   logic flush_a, flush_b, flush_c;
   logic stall_a, stall_b, stall_c;
   logic [1:0] occ_a, occ_b, occ_c;

   int vecs = 0;
   int errs = 0;

   localparam logic [31:0] RV_B = 32'hCAFE_F00D;

   pipe_skid_stage_if #(.DATA_W(32)) ia ();
   pipe_skid_stage_if #(.DATA_W(32)) ib ();
   pipe_skid_stage_if #(.DATA_W(64)) ic ();

   pipe_skid_stage #(.DATA_W(32), .SKID(1), .CLR_ON_FLUSH(1)) dut_a (
      .clk(clk), .rst(rst_a), .flush(flush_a), .stall(stall_a), .bus(ia), .occ(occ_a));
   pipe_skid_stage #(.DATA_W(32), .SKID(0), .CLR_ON_FLUSH(0), .RST_VAL(RV_B)) dut_b (
      .clk(clk), .rst(rst_b), .flush(flush_b), .stall(stall_b), .bus(ib), .occ(occ_b));
   pipe_skid_stage #(.DATA_W(64), .SKID(1), .CLR_ON_FLUSH(1)) dut_c (
      .clk(clk), .rst(rst_c), .flush(flush_c), .stall(stall_c), .bus(ic), .occ(occ_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1; rst_b = 1; rst_c = 1;
      tick(); tick();
      rst_a = 0; rst_b = 0; rst_c = 0;
      vecs++; if (occ_a !== 2'd0) begin errs++; $display("FAIL rst_occ_a: got %0d want 0", occ_a); end
      vecs++; if (ia.out_valid !== 1'b0) begin errs++; $display("FAIL rst_ov_a: got %b want 0", ia.out_valid); end
      vecs++; if (ia.in_ready !== 1'b1) begin errs++; $display("FAIL rst_ir_a: got %b want 1", ia.in_ready); end
      vecs++; if (ia.out_data !== 32'h0) begin errs++; $display("FAIL rst_od_a: got %h want 0", ia.out_data); end
      vecs++; if (ib.out_data !== RV_B) begin errs++; $display("FAIL rst_od_b: got %h want %h", ib.out_data, RV_B); end
      vecs++; if (ib.in_ready !== 1'b1) begin errs++; $display("FAIL rst_ir_b: got %b want 1", ib.in_ready); end
      vecs++; if (occ_c !== 2'd0) begin errs++; $display("FAIL rst_occ_c: got %0d want 0", occ_c); end
   endtask

   task automatic test_stream();
      ia.out_ready = 1; ia.in_valid = 1;
      for (int i = 1; i <= 8; i++) begin
         ia.in_data = 32'(i);
         tick();
         vecs++; if (ia.out_data !== 32'(i)) begin errs++; $display("FAIL stream_od[%0d]: got %h want %h", i, ia.out_data, i); end
         vecs++; if (occ_a !== 2'd1) begin errs++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occ_a); end
         vecs++; if (ia.in_ready !== 1'b1) begin errs++; $display("FAIL stream_ir[%0d]: got %b want 1", i, ia.in_ready); end
      end
      ia.in_valid = 0;
      tick();
      vecs++; if (occ_a !== 2'd0) begin errs++; $display("FAIL stream_drain: occ %0d want 0", occ_a); end
   endtask

   task automatic test_backpressure();
      ia.out_ready = 0; ia.in_valid = 1; ia.in_data = 32'hA;
      tick();
      vecs++; if (occ_a !== 2'd1 || ia.out_data !== 32'hA) begin errs++; $display("FAIL bp_first: occ %0d od %h want 1/a", occ_a, ia.out_data); end
      ia.in_data = 32'hB;
      tick();
      vecs++; if (occ_a !== 2'd2) begin errs++; $display("FAIL bp_occ: got %0d want 2", occ_a); end
      vecs++; if (ia.in_ready !== 1'b0) begin errs++; $display("FAIL bp_ir: got %b want 0", ia.in_ready); end
      vecs++; if (ia.out_data !== 32'hA) begin errs++; $display("FAIL bp_od: got %h want a", ia.out_data); end
      // offered word while full must be ignored; in_ready must not follow out_ready
      ia.in_data = 32'hEE; ia.out_ready = 1;
      #1;
      vecs++; if (ia.in_ready !== 1'b0) begin errs++; $display("FAIL bp_comb_ir: got %b want 0", ia.in_ready); end
      tick();
      ia.in_valid = 0;
      vecs++; if (ia.out_data !== 32'hB || occ_a !== 2'd1) begin errs++; $display("FAIL bp_second: od %h occ %0d want b/1", ia.out_data, occ_a); end
      vecs++; if (ia.in_ready !== 1'b1) begin errs++; $display("FAIL bp_ir_back: got %b want 1", ia.in_ready); end
      tick();
      vecs++; if (occ_a !== 2'd0 || ia.out_valid !== 1'b0) begin errs++; $display("FAIL bp_drain: occ %0d ov %b want 0/0", occ_a, ia.out_valid); end
   endtask

   task automatic test_stall_skid();
      ia.out_ready = 1; stall_a = 1; ia.in_valid = 1; ia.in_data = 32'h31;
      tick();
      ia.in_data = 32'h32;
      tick();
      vecs++; if (occ_a !== 2'd2 || ia.out_data !== 32'h31) begin errs++; $display("FAIL stall_fill: occ %0d od %h want 2/31", occ_a, ia.out_data); end
      vecs++; if (ia.in_ready !== 1'b0) begin errs++; $display("FAIL stall_ir: got %b want 0", ia.in_ready); end
      stall_a = 0; ia.in_valid = 0;
      tick();
      vecs++; if (occ_a !== 2'd1 || ia.out_data !== 32'h32) begin errs++; $display("FAIL stall_release: occ %0d od %h want 1/32", occ_a, ia.out_data); end
      tick();
      vecs++; if (occ_a !== 2'd0) begin errs++; $display("FAIL stall_drain: occ %0d want 0", occ_a); end
   endtask

   task automatic test_flush();
      ia.out_ready = 0; ia.in_valid = 1; ia.in_data = 32'hA;
      tick();
      ia.in_data = 32'hB;
      tick();
      flush_a = 1; ia.in_data = 32'hC;
      tick();
      flush_a = 0; ia.in_valid = 0; ia.out_ready = 1;
      vecs++; if (occ_a !== 2'd0 || ia.out_valid !== 1'b0) begin errs++; $display("FAIL flush_occ: occ %0d ov %b want 0/0", occ_a, ia.out_valid); end
      vecs++; if (ia.in_ready !== 1'b1) begin errs++; $display("FAIL flush_ir: got %b want 1", ia.in_ready); end
      vecs++; if (ia.out_data !== 32'h0) begin errs++; $display("FAIL flush_od: got %h want 0", ia.out_data); end
      tick();
      vecs++; if (ia.out_valid !== 1'b0) begin errs++; $display("FAIL flush_ghost: ov %b od %h want 0", ia.out_valid, ia.out_data); end
   endtask

   task automatic test_reset_priority();
      ia.out_ready = 0; ia.in_valid = 1; ia.in_data = 32'h1;
      tick();
      ia.in_data = 32'h2;
      tick();
      rst_a = 1; flush_a = 1; ia.in_data = 32'h3;
      tick();
      rst_a = 0; flush_a = 0; ia.in_valid = 0;
      vecs++; if (occ_a !== 2'd0 || ia.out_data !== 32'h0 || ia.in_ready !== 1'b1) begin
         errs++; $display("FAIL rstpri_a: occ %0d od %h ir %b want 0/0/1", occ_a, ia.out_data, ia.in_ready); end
      // single-register stage holds data on flush, so only reset can load RST_VAL
      ib.out_ready = 0; ib.in_valid = 1; ib.in_data = 32'h11;
      tick();
      rst_b = 1; flush_b = 1; ib.in_data = 32'h22;
      tick();
      rst_b = 0; flush_b = 0; ib.in_valid = 0;
      vecs++; if (ib.out_data !== RV_B) begin errs++; $display("FAIL rstpri_b_od: got %h want %h", ib.out_data, RV_B); end
      vecs++; if (occ_b !== 2'd0 || ib.in_ready !== 1'b1) begin errs++; $display("FAIL rstpri_b: occ %0d ir %b want 0/1", occ_b, ib.in_ready); end
   endtask

   task automatic test_stall_single();
      ib.in_valid = 1; ib.in_data = 32'h5; ib.out_ready = 1; stall_b = 0;
      tick();
      vecs++; if (ib.out_data !== 32'h5 || occ_b !== 2'd1) begin errs++; $display("FAIL ss_load: od %h occ %0d want 5/1", ib.out_data, occ_b); end
      stall_b = 1; ib.in_data = 32'h6;
      #1;
      vecs++; if (ib.in_ready !== 1'b0) begin errs++; $display("FAIL ss_ir_stall: got %b want 0", ib.in_ready); end
      tick();
      vecs++; if (ib.out_data !== 32'h5 || occ_b !== 2'd1) begin errs++; $display("FAIL ss_hold: od %h occ %0d want 5/1", ib.out_data, occ_b); end
      stall_b = 0;
      #1;
      vecs++; if (ib.in_ready !== 1'b1) begin errs++; $display("FAIL ss_ir_go: got %b want 1", ib.in_ready); end
      tick();
      vecs++; if (ib.out_data !== 32'h6 || occ_b !== 2'd1) begin errs++; $display("FAIL ss_swap: od %h occ %0d want 6/1", ib.out_data, occ_b); end
      ib.in_valid = 0;
      tick();
      vecs++; if (occ_b !== 2'd0 || ib.out_valid !== 1'b0) begin errs++; $display("FAIL ss_drain: occ %0d ov %b want 0/0", occ_b, ib.out_valid); end
   endtask

   task automatic test_flush_hold();
      ib.in_valid = 1; ib.in_data = 32'h77; ib.out_ready = 0;
      tick();
      vecs++; if (occ_b !== 2'd1 || ib.in_ready !== 1'b0) begin errs++; $display("FAIL fh_full: occ %0d ir %b want 1/0", occ_b, ib.in_ready); end
      flush_b = 1; ib.in_data = 32'h88;
      tick();
      flush_b = 0; ib.in_valid = 0;
      vecs++; if (occ_b !== 2'd0 || ib.out_valid !== 1'b0 || ib.in_ready !== 1'b1) begin
         errs++; $display("FAIL fh_state: occ %0d ov %b ir %b want 0/0/1", occ_b, ib.out_valid, ib.in_ready); end
      vecs++; if (ib.out_data !== 32'h77) begin errs++; $display("FAIL fh_od: got %h want 77", ib.out_data); end
   endtask

   task automatic test_random();
      logic [63:0] q[$];
      logic        r0, r1, do_enq, do_deq;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         vecs++; if (occ_c !== 2'(q.size())) begin errs++; $display("FAIL rnd_occ[%0d]: got %0d want %0d", cyc, occ_c, q.size()); end
         vecs++; if (ic.in_ready !== (q.size() < 2)) begin errs++; $display("FAIL rnd_ir[%0d]: got %b want %b", cyc, ic.in_ready, q.size() < 2); end
         vecs++; if (ic.out_valid !== (q.size() != 0)) begin errs++; $display("FAIL rnd_ov[%0d]: got %b", cyc, ic.out_valid); end
         if (q.size() != 0) begin
            vecs++; if (ic.out_data !== q[0]) begin errs++; $display("FAIL rnd_od[%0d]: got %h want %h", cyc, ic.out_data, q[0]); end
         end
         ic.in_valid  = ($urandom_range(0, 3) != 0);
         ic.out_ready = ($urandom_range(0, 2) != 0);
         stall_c      = ($urandom_range(0, 4) == 0);
         flush_c      = ($urandom_range(0, 199) == 0);
         ic.in_data   = {$urandom, $urandom};
         #1;
         r0 = ic.in_ready;
         ic.out_ready = !ic.out_ready; stall_c = !stall_c; flush_c = !flush_c;
         #1;
         r1 = ic.in_ready;
         ic.out_ready = !ic.out_ready; stall_c = !stall_c; flush_c = !flush_c;
         vecs++; if (r0 !== r1) begin errs++; $display("FAIL rnd_comb[%0d]: in_ready %b -> %b", cyc, r0, r1); end
         if (flush_c) begin
            q.delete();
         end else begin
            do_deq = (q.size() != 0) && ic.out_ready && !stall_c;
            do_enq = ic.in_valid && (q.size() < 2);
            if (do_deq) void'(q.pop_front());
            if (do_enq) q.push_back(ic.in_data);
         end
         tick();
      end
      ic.in_valid = 0; flush_c = 0;
   endtask

   initial begin
      rst_a = 1; rst_b = 1; rst_c = 1;
      flush_a = 0; flush_b = 0; flush_c = 0;
      stall_a = 0; stall_b = 0; stall_c = 0;
      ia.in_valid = 0; ia.in_data = '0; ia.out_ready = 0;
      ib.in_valid = 0; ib.in_data = '0; ib.out_ready = 0;
      ic.in_valid = 0; ic.in_data = '0; ic.out_ready = 0;
      #1;
      test_reset();
      test_stream();
      test_backpressure();
      test_stall_skid();
      test_flush();
      test_reset_priority();
      test_stall_single();
      test_flush_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits.
REQ-002 SHALL have parameter SKID, default 1; 0 = single-entry register, 1 = two-entry skid buffer with registered in_ready.
REQ-003 SHALL have parameter CLR_ON_FLUSH, default 1; 1 = data registers load RST_VAL on flush, 0 = data registers hold on flush.
REQ-004 SHALL have parameter RST_VAL, default all-zero DATA_W vector, payload value after reset.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  discard all held and incoming entries.
REQ-008 SHALL have port stall  input  1  block dequeue while high.
REQ-009 SHALL have port in_valid  input  1  upstream entry present.
REQ-010 SHALL have port in_ready  output  1  stage accepts entry this cycle.
REQ-011 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-012 SHALL have port out_valid  output  1  stage holds valid entry.
REQ-013 SHALL have port out_ready  input  1  downstream accepts entry.
REQ-014 SHALL have port out_data  output  DATA_W  payload of oldest entry.
REQ-015 SHALL have port occ  output  2  entries held (0..2; never exceeds 1 when SKID=0).

Function
REQ-016 SHALL define enq = in_valid & in_ready & !flush, and deq = out_valid & out_ready & !stall & !flush.
REQ-017 SHALL drive out_data from the main register only; skid register never drives outputs directly.
REQ-018 SKID=1 SHALL implement states EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
REQ-019 EMPTY: enq -> ONE, main <= in_data; else stay.
REQ-020 ONE: enq & deq -> ONE, main <= in_data; enq & !deq -> FULL, skid <= in_data; !enq & deq -> EMPTY; else hold.
REQ-021 FULL: deq -> ONE, main <= skid; else hold; no enq possible.
REQ-022 SKID=1 SHALL drive in_ready = (state != FULL) from a register, with no combinational path from out_ready, stall or flush.
REQ-023 SKID=0 SHALL drive in_ready = !out_valid | (out_ready & !stall), combinational; enq loads main and sets out_valid; deq without enq clears out_valid.
REQ-024 SHALL drive out_valid = (occ != 0).
REQ-025 Latency SHALL be one cycle: an entry enqueued in cycle N is visible on out_data/out_valid in cycle N+1 if the stage was EMPTY, or when ONE and dequeued in cycle N.
REQ-026 SHALL preserve FIFO order; no entry dropped or duplicated except by flush.
REQ-027 flush SHALL take priority over stall, enq and deq: next cycle occ=0, out_valid=0, in_ready=1; data registers per CLR_ON_FLUSH.
REQ-028 stall with out_ready=1 SHALL still accept input while in_ready=1 (fills skid when SKID=1).
REQ-029 out_data SHALL remain stable while out_valid=1 and no deq occurs.
REQ-030 in_data SHALL be ignored whenever enq=0.

Reset
REQ-031 rst SHALL take priority over flush and all other inputs.
REQ-032 After rst: state EMPTY, occ=0, out_valid=0, in_ready=1, out_data=RST_VAL, skid=RST_VAL.
REQ-033 rst asserted mid-operation (any occupancy) SHALL discard all entries in one cycle, with the same values as REQ-032.

Verification
REQ-034 Stream: SKID=1, out_ready=1, in_valid=1 every cycle, data 1,2,3,... -> out_data 1,2,3,... one cycle later, occ stays 1, in_ready stays 1.
REQ-035 Backpressure: SKID=1, out_ready=0, send 0xA then 0xB -> occ=2, in_ready=0, out_data=0xA; then out_ready=1 -> 0xA, 0xB out in consecutive cycles, in_ready=1 one cycle after first deq.
REQ-036 Stall: SKID=0, out_valid=1 holding 0x5, stall=1, out_ready=1 -> in_ready=0, out_data stays 0x5; stall=0 -> deq of 0x5 and enq of next word in the same cycle.
REQ-037 Flush: SKID=1 FULL (0xA,0xB), flush=1 with in_valid=1, in_data=0xC -> next cycle occ=0, out_valid=0, in_ready=1, out_data=0 (CLR_ON_FLUSH=1); 0xC never appears.
REQ-038 Reset priority: FULL, rst=1 and flush=1 with in_valid=1 -> next cycle occ=0, out_data=RST_VAL, in_ready=1.
REQ-039 Random: random in_valid/out_ready/stall, 10k cycles, DATA_W=64 -> output sequence equals input sequence, occ never exceeds 2, in_ready never depends combinationally on out_ready (SKID=1).
